// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcode/funct constants and per-state control words for the multicycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // fetch/branch/pcwrite are qualifiers combined with memready/zero at the outputs
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       fetch;
        logic       branch;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.alusrcb = 2'b01; c.fetch = 1'b1; end
            S_DECODE: c.alusrcb = 2'b11;
            S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:  c.iord = 1'b1;
            S_MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXEC:   begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
            S_ALUWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_BRANCH: begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
            S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB: c.regwrite = 1'b1;
            S_JUMP:   begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - ALU operation decode from aluop and funct
module mc_aludec
    import mc_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  logic [1:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [2:0]         alucontrol
);

    // R-type funct codes select the ALU op; unknown funct falls back to add
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                if      (funct == FUNCT_W'(FN_ADD)) alucontrol = ALU_ADD;
                else if (funct == FUNCT_W'(FN_SUB)) alucontrol = ALU_SUB;
                else if (funct == FUNCT_W'(FN_AND)) alucontrol = ALU_AND;
                else if (funct == FUNCT_W'(FN_OR))  alucontrol = ALU_OR;
                else if (funct == FUNCT_W'(FN_SLT)) alucontrol = ALU_SLT;
                else                                alucontrol = ALU_ADD;
            end
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM; `MC_CONTROLLER_BNE_EN adds bne support
module mc_controller
    import mc_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int FUNCT_W   = 6,
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    input  logic                 memready,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 pcen,
    output logic                 regwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal_op,
    output logic [3:0]           state
);

    state_t     r_state;
    ctrl_t      r_ctrl;
    state_t     w_next;
    logic       w_decode_ok;
    logic       w_is_branch;
    logic       w_bne_sel;
    logic       w_taken;
    logic [2:0] w_alu3;

`ifdef MC_CONTROLLER_BNE_EN
    assign w_is_branch = (op == OP_W'(OP_BEQ)) || (op == OP_W'(OP_BNE));
    assign w_bne_sel   = (op == OP_W'(OP_BNE));
`else
    assign w_is_branch = (op == OP_W'(OP_BEQ));
    assign w_bne_sel   = 1'b0;
`endif

    // next-state sequencing; memory states hold until memready
    always_comb begin
        w_next      = r_state;
        w_decode_ok = 1'b0;
        case (r_state)
            S_FETCH:  if (memready) w_next = S_DECODE;
            S_DECODE: begin
                w_decode_ok = 1'b1;
                if ((op == OP_W'(OP_LW)) || (op == OP_W'(OP_SW))) w_next = S_MEMADR;
                else if (op == OP_W'(OP_RTYPE))                   w_next = S_EXEC;
                else if (w_is_branch)                             w_next = S_BRANCH;
                else if (op == OP_W'(OP_ADDI))                    w_next = S_ADDIEX;
                else if (op == OP_W'(OP_J))                       w_next = S_JUMP;
                else begin
                    w_next      = S_FETCH;
                    w_decode_ok = 1'b0;
                end
            end
            S_MEMADR: w_next = (op == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (memready) w_next = S_MEMWB;
            S_MEMWR:  if (memready) w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // state register with control word registered alongside it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= state_ctrl(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next);
        end
    end

    mc_aludec #(.FUNCT_W(FUNCT_W)) u_aludec (
        .aluop      (r_ctrl.aluop),
        .funct      (funct),
        .alucontrol (w_alu3)
    );

    assign w_taken = r_ctrl.branch & (w_bne_sel ? ~zero : zero);

    // enables are forced low for the whole reset interval
    always_comb begin
        iord       = r_ctrl.iord;
        memwrite   = r_ctrl.memwrite & ~reset;
        irwrite    = r_ctrl.fetch & memready & ~reset;
        pcen       = ~reset & (r_ctrl.pcwrite | (r_ctrl.fetch & memready) | w_taken);
        regwrite   = r_ctrl.regwrite & ~reset;
        regdst     = r_ctrl.regdst;
        memtoreg   = r_ctrl.memtoreg;
        alusrca    = r_ctrl.alusrca;
        alusrcb    = r_ctrl.alusrcb;
        pcsrc      = r_ctrl.pcsrc;
        alucontrol = ALUCTRL_W'(w_alu3);
        illegal_op = (r_state == S_DECODE) & ~w_decode_ok & ~reset;
        state      = r_state;
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized self-checking bench for mc_controller against an instruction-level model
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MC_CONTROLLER_BNE_EN
    localparam bit BNE_ON = 1'b1;
`else
    localparam bit BNE_ON = 1'b0;
`endif

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] got_vec();
        return {iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, alucontrol, illegal_op};
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // instruction class -> sequence of visited states
    task automatic build_path(input logic [5:0] o, output int p[$]);
        p = '{0, 1};
        case (o)
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5};
            6'b000000: p = '{0, 1, 6, 7};
            6'b000100: p = '{0, 1, 8};
            6'b000101: if (BNE_ON) p = '{0, 1, 8};
            6'b001000: p = '{0, 1, 9, 10};
            6'b000010: p = '{0, 1, 11};
            default:   p = '{0, 1};
        endcase
    endtask

    // control outputs expected while the instruction is in phase s
    function automatic logic [15:0] exp_vec(input int s, input logic [5:0] o, input logic [5:0] f,
                                            input logic z, input logic mr, input bit legal);
        logic io, mw, ir, pe, rw, rd, mt, sa, il;
        logic [1:0] sb, ps;
        logic [2:0] alu;
        {io, mw, ir, pe, rw, rd, mt, sa, il} = '0;
        sb = 2'b00; ps = 2'b00; alu = 3'b010;
        case (s)
            0:  begin sb = 2'b01; ir = mr; pe = mr; end
            1:  begin sb = 2'b11; il = !legal; end
            2:  begin sa = 1'b1; sb = 2'b10; end
            3:  io = 1'b1;
            4:  begin mt = 1'b1; rw = 1'b1; end
            5:  begin io = 1'b1; mw = 1'b1; end
            6:  begin sa = 1'b1; alu = funct_alu(f); end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin sa = 1'b1; alu = 3'b110; ps = 2'b01; pe = (o == 6'b000101) ? !z : z; end
            9:  begin sa = 1'b1; sb = 2'b10; end
            10: rw = 1'b1;
            11: begin ps = 2'b10; pe = 1'b1; end
            default: ;
        endcase
        return {io, mw, ir, pe, rw, rd, mt, sa, sb, ps, alu, il};
    endfunction

    // wait_n < 0: random memready stalls; zero_v < 0: random zero flag
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int wait_n, input int zero_v);
        int  p[$];
        int  s, nw;
        bit  wt;
        build_path(o, p);
        op = o;
        funct = f;
        foreach (p[k]) begin
            s  = p[k];
            wt = (s == 0) || (s == 3) || (s == 5);
            nw = !wt ? 0 : (wait_n >= 0) ? wait_n : (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
            for (int c = 0; c <= nw; c++) begin
                memready = wt ? (c == nw) : 1'($urandom_range(0, 1));
                zero     = (zero_v >= 0) ? 1'(zero_v) : 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("state", 32'(state), 32'(s));
                chk("ctrl", 32'(got_vec()), 32'(exp_vec(s, o, f, zero, memready, p.size() > 2)));
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic reset_mid_sw();
        op = 6'b101011; funct = '0; memready = 1'b1; zero = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        memready = 1'b0;
        @(negedge clk);
        chk("memwr_state", 32'(state), 32'd5);
        chk("memwr_strobe", 32'(memwrite), 32'd1);
        #2;
        reset = 1'b1;
        memready = 1'b1;
        #1;
        chk("rst_memwrite", 32'(memwrite), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_enables", 32'({irwrite, pcen, regwrite}), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_state", 32'(state), 32'd0);
        memready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_state", 32'(state), 32'd0);
    endtask

    logic [5:0] ops[8];
    logic [5:0] fns[6];

    initial begin
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        reset = 1'b1; op = 6'b000010; funct = '0; zero = 1'b1; memready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_enables", 32'({memwrite, irwrite, pcen, regwrite}), 32'd0);
        chk("reset_illegal", 32'(illegal_op), 32'd0);
        memready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_instr(6'b100011, 6'b000000, 0, -1);
        run_instr(6'b101011, 6'b000000, 3, -1);
        run_instr(6'b000100, 6'b000000, 0, 1);
        run_instr(6'b000100, 6'b000000, 0, 0);
        run_instr(6'b000000, 6'b101010, 0, -1);
        run_instr(6'b111111, 6'b000000, 0, -1);
        run_instr(6'b000101, 6'b000000, 0, 0);
        run_instr(6'b000101, 6'b000000, 0, 1);
        run_instr(6'b000010, 6'b000000, 2, -1);
        reset_mid_sw();

        for (int i = 0; i < 200; i++) begin
            logic [5:0] o, f;
            o = ops[$urandom_range(0, 7)];
            if (o == 6'b111111) o = 6'($urandom);
            f = fns[$urandom_range(0, 5)];
            if (f == 6'b000000) f = 6'($urandom);
            run_instr(o, f, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
